tone_mixer: RTL

- Consumer end of the four-voice frequency interface: takes the four 8-bit half-period words (freq1..freq4) driven by the input-controls block.
- Each word is turned into a square-wave voice. The four voices are summed into a 10-bit sample.
- The sample drives a single-pin PWM audio output.
- A freq value of 0 means the voice is silent.

---
 rtl/tone_mixer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tone_mixer.sv
// -----------------------------------------------------------------------------
// tone_mixer
//
// Four-voice square-wave synthesiser with a PWM audio output. Each 8-bit
// frequency word is a half-period length in voice ticks; 0 silences the
// voice. The high phases of the voices are summed into a 10-bit sample. A
// free-running 1020-clock PWM frame latches that sample and turns it into a
// pulse width on a single output pin.
//
// Parameters:
//   TICK_DIV       clocks per voice tick (1 = every clock)
//   AMP            level a voice adds to the sample while in its high phase
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   freq1..freq4   per-voice half-period in ticks, 0 = off
//   voice_active   bit i high while voice i+1 is running
//   audio_sample   registered sum of the voice levels (0..1020)
//   sample_strobe  one-clock pulse when the PWM frame latches a new sample
//   audio_pwm      PWM audio output
// -----------------------------------------------------------------------------
module tone_mixer #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned AMP      = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] freq1,
  input  logic [7:0] freq2,
  input  logic [7:0] freq3,
  input  logic [7:0] freq4,
  output logic [3:0] voice_active,
  output logic [9:0] audio_sample,
  output logic       sample_strobe,
  output logic       audio_pwm
);

  localparam int unsigned PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [9:0]  AMP_W      = 10'(AMP);
  localparam logic [9:0]  FRAME_LAST = 10'd1019;

  // Prescaler
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  // Voice state, index i belongs to voice i+1
  logic [3:0][7:0] freq_w;
  logic [3:0][7:0] cur_q, cur_d;
  logic [3:0][7:0] cnt_q, cnt_d;
  logic [3:0]      ph_q,  ph_d;
  logic [3:0]      voice_active_q, voice_active_d;

  // Mixer and PWM
  logic [9:0] audio_sample_q, audio_sample_d;
  logic [9:0] pwm_cnt_q, pwm_cnt_d;
  logic [9:0] pwm_hold_q, pwm_hold_d;
  logic       frame_end;
  logic       sample_strobe_q;
  logic       audio_pwm_q, audio_pwm_d;

  assign freq_w = {freq4, freq3, freq2, freq1};

  // With TICK_DIV=1 the counter stays at 0, so tick is high every cycle.
  assign pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
  assign tick  = (pre_q == '0);

  // Per-voice half-period sequencer.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    cur_d = cur_q;
    cnt_d = cnt_q;
    ph_d  = ph_q;
    for (int i = 0; i < 4; i++) begin
      if (tick) begin
        if (cur_q[i] == 8'd0) begin
          // Idle: start a new voice high, or keep it parked at zero.
          cnt_d[i] = 8'd0;
          if (freq_w[i] == 8'd0) begin
            ph_d[i] = 1'b0;
          end else begin
            cur_d[i] = freq_w[i];
            ph_d[i]  = 1'b1;
          end
        end else if (freq_w[i] == 8'd0) begin
          // Silence takes effect on this tick, without waiting for the
          // end of the current half-period.
          cur_d[i] = 8'd0;
          cnt_d[i] = 8'd0;
          ph_d[i]  = 1'b0;
        end else if (cnt_q[i] == cur_q[i] - 8'd1) begin
          // Half-period boundary: the frequency word is re-sampled only
          // here, so mid-period changes wait for the boundary.
          cur_d[i] = freq_w[i];
          cnt_d[i] = 8'd0;
          ph_d[i]  = ~ph_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    voice_active_d = '0;
    for (int i = 0; i < 4; i++) begin
      voice_active_d[i] = (cur_d[i] != 8'd0);
    end
  end

  // Sum of the current phases; lands in audio_sample one clock after ph.
  always_comb begin
    audio_sample_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (ph_q[i]) begin
        audio_sample_d = audio_sample_d + AMP_W;
      end
    end
  end

  assign frame_end   = (pwm_cnt_q == FRAME_LAST);
  assign pwm_cnt_d   = frame_end ? 10'd0 : pwm_cnt_q + 10'd1;
  assign pwm_hold_d  = frame_end ? audio_sample_q : pwm_hold_q;
  // pwm_cnt never reaches 1020, so a held 1020 keeps the output high all frame.
  assign audio_pwm_d = (pwm_cnt_q < pwm_hold_q);

  // NOTE: the voice arrays are a handful of flops, not a RAM, so clearing
  // them in the async reset costs nothing and keeps start-up deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q           <= '0;
      cur_q           <= '0;
      cnt_q           <= '0;
      ph_q            <= '0;
      voice_active_q  <= '0;
      audio_sample_q  <= '0;
      pwm_cnt_q       <= '0;
      pwm_hold_q      <= '0;
      sample_strobe_q <= 1'b0;
      audio_pwm_q     <= 1'b0;
    end else begin
      // NOTE: state updates are non-blocking so every register samples the
      // pre-edge values, independent of statement order.
      pre_q           <= pre_d;
      cur_q           <= cur_d;
      cnt_q           <= cnt_d;
      ph_q            <= ph_d;
      voice_active_q  <= voice_active_d;
      audio_sample_q  <= audio_sample_d;
      pwm_cnt_q       <= pwm_cnt_d;
      pwm_hold_q      <= pwm_hold_d;
      sample_strobe_q <= frame_end;
      audio_pwm_q     <= audio_pwm_d;
    end
  end

  assign voice_active  = voice_active_q;
  assign audio_sample  = audio_sample_q;
  assign sample_strobe = sample_strobe_q;
  assign audio_pwm     = audio_pwm_q;

endmodule
